// File: rtl/wide_add_seq_if.sv
// wide_add_seq_if: start/ready/done request bus for the sequenced wide adder.
interface wide_add_seq_if #(
    parameter int N     = 5,
    parameter int WORDS = 4
);
    localparam int W = N * WORDS;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    modport master (output start, a, b, cin, input ready, busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, cin, output ready, busy, done, sum, cout, ovf);
endinterface

// File: rtl/wide_add_seq.sv
// wide_add_seq: (N*WORDS)-bit add done one N-bit slice per cycle, LS word first,
// carry chained through a register; result published only on completion.
module wide_add_seq #(
    parameter int N     = 5,
    parameter int WORDS = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    wide_add_seq_if.slave bus
);
    localparam int W  = N * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  op_a, op_b, acc, acc_nxt, sum_q;
    logic [IW-1:0] idx;
    logic          carry, cout_q, ovf_q, last;
    logic [N:0]    slice;

    assign last = (idx == LAST_IDX);

    // acc_nxt carries the current slice so the final word can go straight to sum
    always_comb begin
        slice   = {1'b0, op_a[int'(idx) * N +: N]} + {1'b0, op_b[int'(idx) * N +: N]} + (N + 1)'(carry);
        acc_nxt = acc;
        acc_nxt[int'(idx) * N +: N] = slice[N-1:0];
    end

    always_comb begin
        state_nxt = state;
        state_nxt = (state == IDLE) ? (bus.start ? RUN : IDLE) :
                    (state == RUN)  ? (last ? DONE : RUN) : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a   <= '0;
            op_b   <= '0;
            acc    <= '0;
            idx    <= '0;
            carry  <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (state == IDLE) begin
            if (bus.start) begin
                op_a  <= bus.a;
                op_b  <= bus.b;
                carry <= bus.cin;
                idx   <= '0;
            end
        end else if (state == RUN) begin
            acc   <= acc_nxt;
            carry <= slice[N];
            if (last) begin
                sum_q  <= acc_nxt;
                cout_q <= slice[N];
                ovf_q  <= (op_a[W-1] == op_b[W-1]) && (slice[N-1] != op_a[W-1]);
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign bus.ready = (state == IDLE);
    assign bus.busy  = (state == RUN);
    assign bus.done  = (state == DONE);
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;
    assign bus.ovf   = ovf_q;
endmodule
